morse_char_decoder: RTL and testbench

Parametrised Morse-to-ASCII character decoder. It sits between the symbol classifier, which produces 3-bit dit/dah/gap/space/wait events, and the text sink. It accumulates up to MAX_LEN symbols per character and decodes letters, digits and common punctuation, with explicit error reporting. Decoded characters are buffered in a FIFO behind a valid/ready handshake, so a stalled sink never loses words silently.

---
 rtl/morse_pkg.sv | 18 +
 rtl/morse_lut.sv | 97 +++++++++
 rtl/morse_char_decoder.sv | 139 +++++++++++++
 tb/tb_morse_char_decoder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared definitions for the Morse decoder: symbol encodings, pattern width
// and the ASCII space code pushed for word breaks.
package morse_pkg;

    localparam int PAT_W = 6;

    typedef logic [2:0]       sym_t;
    typedef logic [PAT_W-1:0] pat_t;

    localparam sym_t SYM_WAIT  = 3'd0;
    localparam sym_t SYM_DIT   = 3'd1;
    localparam sym_t SYM_DAH   = 3'd2;
    localparam sym_t SYM_GAP   = 3'd3;
    localparam sym_t SYM_SPACE = 3'd4;

    localparam logic [7:0] ASCII_SPACE = 8'h20;

endpackage

// File: rtl/morse_lut.sv
// Combinational Morse lookup: (len, pat) -> {valid, ascii}. The pattern holds
// the most recent symbol in bit 0, dit=0 and dah=1.
module morse_lut
    import morse_pkg::*;
#(
    parameter int MAX_LEN = 6
) (
    input  logic [2:0] len,
    input  pat_t       pat,
    output logic       valid,
    output logic [7:0] ascii
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        valid = 1'b0;
        ascii = 8'h00;
        case (len)
            3'd1: begin
                valid = 1'b1;
                ascii = pat[0] ? "T" : "E";
            end
            3'd2: begin
                valid = 1'b1;
                case (pat[1:0])
                    2'b00:   ascii = "I";
                    2'b01:   ascii = "A";
                    2'b10:   ascii = "N";
                    default: ascii = "M";
                endcase
            end
            3'd3: begin
                valid = 1'b1;
                case (pat[2:0])
                    3'b000:  ascii = "S";
                    3'b001:  ascii = "U";
                    3'b010:  ascii = "R";
                    3'b011:  ascii = "W";
                    3'b100:  ascii = "D";
                    3'b101:  ascii = "K";
                    3'b110:  ascii = "G";
                    default: ascii = "O";
                endcase
            end
            3'd4: begin
                valid = 1'b1;
                case (pat[3:0])
                    4'b0000: ascii = "H";
                    4'b0001: ascii = "V";
                    4'b0010: ascii = "F";
                    4'b0100: ascii = "L";
                    4'b0110: ascii = "P";
                    4'b0111: ascii = "J";
                    4'b1000: ascii = "B";
                    4'b1001: ascii = "X";
                    4'b1010: ascii = "C";
                    4'b1011: ascii = "Y";
                    4'b1100: ascii = "Z";
                    4'b1101: ascii = "Q";
                    default: valid = 1'b0;  // ..--  .-.-  ---.  ----
                endcase
            end
            3'd5: begin
                valid = 1'b1;
                case (pat[4:0])
                    5'b11111: ascii = "0";
                    5'b01111: ascii = "1";
                    5'b00111: ascii = "2";
                    5'b00011: ascii = "3";
                    5'b00001: ascii = "4";
                    5'b00000: ascii = "5";
                    5'b10000: ascii = "6";
                    5'b11000: ascii = "7";
                    5'b11100: ascii = "8";
                    5'b11110: ascii = "9";
                    default:  valid = 1'b0;
                endcase
            end
            3'd6: begin
                if (MAX_LEN >= 6) begin
                    valid = 1'b1;
                    case (pat[5:0])
                        6'b010101: ascii = ".";
                        6'b110011: ascii = ",";
                        6'b001100: ascii = "?";
                        default:   valid = 1'b0;
                    endcase
                end
            end
            default: begin
                valid = 1'b0;
                ascii = 8'h00;
            end
        endcase
    end

endmodule

// File: rtl/morse_char_decoder.sv
// Morse symbol accumulator and character decoder with an output FIFO behind a
// valid/ready handshake; overlong/invalid codes and FIFO overflow are flagged.
module morse_char_decoder
    import morse_pkg::*;
#(
    parameter int MAX_LEN    = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] sym_in,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       err_code,
    output logic       err_drop,
    output logic       idle
);

    localparam int                PTR_W      = $clog2(FIFO_DEPTH);
    localparam logic [2:0]        LEN_MAX    = 3'(MAX_LEN);
    localparam logic [PTR_W-1:0]  PTR_ONE    = 1;
    localparam logic [PTR_W:0]    COUNT_ONE  = 1;
    localparam logic [PTR_W:0]    COUNT_FULL = (PTR_W+1)'(FIFO_DEPTH);

    logic [2:0]         len;
    logic [MAX_LEN-1:0] pat;
    logic               ovf;
    logic               space_pend;

    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;

    logic       is_dit, is_dah, is_gap, is_space, is_mark;
    logic       commit, code_ok, push_req, do_push, do_pop, full;
    logic [7:0] push_data;
    logic       lut_valid;
    logic [7:0] lut_ascii;
    pat_t       lut_pat;

    assign lut_pat = pat_t'(pat);

    morse_lut #(
        .MAX_LEN(MAX_LEN)
    ) u_lut (
        .len  (len),
        .pat  (lut_pat),
        .valid(lut_valid),
        .ascii(lut_ascii)
    );

    // Codes 5..7 match none of the compares and therefore behave as WAIT.
    assign is_dit   = (sym_in == SYM_DIT);
    assign is_dah   = (sym_in == SYM_DAH);
    assign is_gap   = (sym_in == SYM_GAP);
    assign is_space = (sym_in == SYM_SPACE);
    assign is_mark  = is_dit | is_dah;

    assign commit   = (is_gap | is_space) && (len != 3'd0);
    assign code_ok  = lut_valid && !ovf;
    assign full     = (count == COUNT_FULL);
    assign do_pop   = out_valid && out_ready;

    // At most one push source is live per cycle: a deferred space always sees len==0.
    always_comb begin
        push_req  = 1'b0;
        push_data = ASCII_SPACE;
        if (commit) begin
            push_req  = code_ok;
            push_data = lut_ascii;
        end else if (space_pend || (is_space && len == 3'd0)) begin
            push_req  = 1'b1;
            push_data = ASCII_SPACE;
        end
    end

    assign do_push = push_req && !full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len        <= 3'd0;
            pat        <= '0;
            ovf        <= 1'b0;
            space_pend <= 1'b0;
            err_code   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            err_code   <= commit && !code_ok;
            space_pend <= commit && is_space;
            if (is_mark) begin
                if (len < LEN_MAX) begin
                    pat <= {pat[MAX_LEN-2:0], is_dah};
                    len <= len + 3'd1;
                end else begin
                    ovf <= 1'b1;
                end
            end else if (commit) begin
                len <= 3'd0;
                pat <= '0;
                ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the storage is reset too, so out_data reads 0x00 during reset.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            err_drop <= 1'b0;
        end else begin
            // Full is judged on the pre-pop count, so a simultaneous pop does not rescue a push.
            err_drop <= push_req && full;
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
        end
    end

    assign out_data  = mem[rd_ptr];
    assign out_valid = (count != '0);
    assign idle      = (len == 3'd0) && !space_pend;

endmodule

// File: tb/tb_morse_char_decoder.sv
// Scoreboard bench for morse_char_decoder: directed symbol streams push
// expected characters; a negedge monitor compares every handshake pop.
module tb_morse_char_decoder;
    import morse_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] sym_in = SYM_WAIT;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       err_code;
    logic       err_drop;
    logic       idle;

    int         checks = 0;
    int         errors = 0;
    int         n_err_code = 0;
    int         n_err_drop = 0;
    logic [7:0] exp_q [$];

    morse_char_decoder #(
        .MAX_LEN   (6),
        .FIFO_DEPTH(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sym_in   (sym_in),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .err_code (err_code),
        .err_drop (err_drop),
        .idle     (idle)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Pops happen on the next rising edge; negedge sampling sees stable data.
    always @(negedge clk) begin
        if (rst_n) begin
            if (err_code) n_err_code++;
            if (err_drop) n_err_drop++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: got 0x%0h, expected no output", out_data);
                end else begin
                    check("pop_data", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic send(input sym_t s);
        sym_in = s;
        @(posedge clk);
        #1;
        sym_in = SYM_WAIT;
    endtask

    task automatic send_code(input string code);
        for (int i = 0; i < code.len(); i++) begin
            send((code[i] == "-") ? SYM_DAH : SYM_DIT);
        end
        send(SYM_GAP);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    string      codes [6] = '{"--.-", ".-.-.-", "--..--", "..--..", ".----", "-..."};
    logic [7:0] chars [6] = '{8'h51, 8'h2E, 8'h2C, 8'h3F, 8'h31, 8'h42};

    initial begin
        int base;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_idle", idle, 1);
        check("rst_err_code", err_code, 0);
        check("rst_err_drop", err_drop, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 'A': visible the cycle after GAP, popped on the next edge.
        out_ready = 1'b1;
        send(SYM_DIT);
        send(SYM_DAH);
        exp_q.push_back(8'h41);
        send(SYM_GAP);
        check("a_valid", out_valid, 1);
        check("a_data", out_data, 8'h41);
        check("a_err_code", err_code, 0);
        drain();

        // '0' then '4', idle after each commit.
        exp_q.push_back(8'h30);
        send_code("-----");
        check("idle_after_0", idle, 1);
        exp_q.push_back(8'h34);
        send_code("....-");
        check("idle_after_4", idle, 1);
        drain();

        // Unused 4-symbol code then 'T'.
        base = n_err_code;
        send_code("..--");
        check("inv4_err_pulse", err_code, 1);
        check("inv4_no_push", out_valid, 0);
        send(SYM_WAIT);
        check("inv4_err_one_cycle", err_code, 0);
        check("inv4_err_count", n_err_code - base, 1);
        exp_q.push_back(8'h54);
        send_code("-");
        drain();

        // Seven dits overflow a 6-symbol accumulator; then 'E'.
        base = n_err_code;
        send_code(".......");
        check("ovf_err_pulse", err_code, 1);
        check("ovf_fifo_empty", out_valid, 0);
        exp_q.push_back(8'h45);
        send_code(".");
        drain();
        check("ovf_err_count", n_err_code - base, 1);

        // Assorted letters, digits and punctuation.
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(chars[i]);
            send_code(codes[i]);
        end
        drain();

        // Fill a stalled 4-deep FIFO; the fifth push is dropped.
        out_ready = 1'b0;
        base = n_err_drop;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_q.push_back(8'h45);
            send_code(".");
        end
        check("full_err_drop", err_drop, 1);
        check("full_valid", out_valid, 1);
        check("full_head_stable", out_data, 8'h45);
        send(SYM_WAIT);
        check("full_drop_count", n_err_drop - base, 1);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("full_drained_4_cycles", out_valid, 0);
        check("full_queue_empty", exp_q.size(), 0);

        // Deferred space after a committed 'T'.
        exp_q.push_back(8'h54);
        exp_q.push_back(8'h20);
        send(SYM_DAH);
        send(SYM_SPACE);
        check("space_pend_not_idle", idle, 0);
        check("space_t_data", out_data, 8'h54);
        send(SYM_WAIT);
        check("space_idle_after", idle, 1);
        check("space_data", out_data, 8'h20);
        drain();

        // Standalone space.
        exp_q.push_back(8'h20);
        send(SYM_SPACE);
        drain();

        // Reset mid-character discards the partial code silently.
        base = n_err_code;
        send(SYM_DIT);
        send(SYM_DIT);
        rst_n = 1'b0;
        #1;
        check("midrst_idle", idle, 1);
        check("midrst_valid", out_valid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.push_back(8'h54);
        send_code("-");
        drain();
        send(SYM_WAIT);
        check("midrst_no_err", n_err_code - base, 0);
        check("final_empty", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
